traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
- Sequences a two-road intersection (main/side) plus a pedestrian crossing.
- Inputs are single-cycle request pulses from the upstream edge detectors (button and car sensor) and a 1 Hz timebase enable.
- Registered light outputs drive the board LEDs.
- A one-cycle phase-change pulse feeds the PS interrupt line so software can log and override the sequencing.

Parameters:
- GREEN_TICKS, 10, minimum green duration in ticks, main and side (must be >= 1).
- YELLOW_TICKS, 3, yellow duration in ticks (>= 1).
- ALLRED_TICKS, 2, all-red clearance duration in ticks (>= 1).
- WALK_TICKS, 8, pedestrian walk duration in ticks (>= 1).
- CNT_W, 8, phase counter width; every *_TICKS parameter must be < 2**CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  timebase enable, one-cycle pulse per second
- ped_req  in  1  pedestrian button rising-edge pulse
- side_req  in  1  side-road car sensor rising-edge pulse
- main_light  out  3  {red,yellow,green}, one-hot
- side_light  out  3  {red,yellow,green}, one-hot
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding
- irq  out  1  one-cycle pulse on every state change

Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values: phase=0 (MG), main_light=001, side_light=100, walk=0, irq=0, cnt=0, ped_pend=0, side_pend=0.
- States and outputs (main/side/walk):
  - MG=0: 001/100/0
  - MY=1: 010/100/0
  - AR1=2: 100/100/0
  - SG=3: 100/001/0
  - SY=4: 100/010/0
  - AR2=5: 100/100/0
  - WK=6: 100/100/1
  - FL=7: see optional feature
- Counter:
  - cnt clears to 0 in the cycle the state changes.
  - Otherwise cnt increments on each tick.
  - In MG, cnt saturates at GREEN_TICKS-1.
  - Every state lasts exactly N ticks; it exits on the tick where cnt==N-1.
- Transitions (all evaluated only when tick=1):
  - MG -> MY: cnt==GREEN_TICKS-1 and (ped_pend or side_pend). Otherwise MG holds indefinitely.
  - MY -> AR1 after YELLOW_TICKS.
  - AR1 -> WK if ped_pend, else SG, after ALLRED_TICKS. Pedestrian has priority.
  - SG -> SY after GREEN_TICKS; SY -> AR2 after YELLOW_TICKS.
  - WK -> AR2 after WALK_TICKS.
  - AR2 -> MG after ALLRED_TICKS.
  - A request still pending after WK/SG is served on the next cycle through MG.
- Pending latches:
  - ped_pend sets on ped_req and clears in the cycle WK is entered.
  - side_pend sets on side_req and clears in the cycle SG is entered.
  - If set and clear coincide, set wins (the latch stays 1).
  - Requests arriving in any state are latched.
- Outputs are registered and update in the same cycle as phase. There is no combinational path from inputs to outputs.
- irq=1 for exactly the one cycle in which phase holds its new value.
- Back-to-back tick on consecutive cycles is legal; each tick counts.
- tick=0 forever freezes the state; requests still latch.
- rst_n asserted mid-phase returns all registers to their reset values immediately (asynchronous). Pending requests are lost.

Optional Feature:
- Macro: NIGHT_FLASH_EN.
- Defined:
  - Adds input port night_mode (1 bit).
  - In MG, a tick with night_mode=1 enters FL; this takes precedence over the request exit.
  - In FL, the main yellow (main_light 010/000) and side red (side_light 100/000) both toggle on every tick, starting lit on entry. walk=0.
  - Requests latch but are not served in FL.
  - A tick with night_mode=0 exits FL to AR2, then returns to MG. irq pulses on FL entry and exit only, not on toggles.
- Not defined: no night_mode port, FL is unreachable, and state encoding 7 never appears.

Test Plan:
- Reset then 20 ticks with no requests -> phase stays 0, main_light=001, side_light=100, no irq pulses.
- side_req at tick 2 -> MG exits at tick 10 boundary. Sequence MY(3 ticks) -> AR1(2) -> SG(10) -> SY(3) -> AR2(2) -> MG, with 6 irq pulses; side_pend cleared on SG entry.
- ped_req and side_req in the same cycle -> AR1 goes to WK (walk=1 for 8 ticks) -> AR2 -> MG. MG then exits again after 10 ticks and serves SG.
- side_req on the exact cycle SG is entered -> side_pend remains 1, and a second SG phase follows the next MG.
- rst_n low for 1 cycle during SG cnt=5 -> outputs return to reset values asynchronously; after release, MG lasts at least 10 ticks.
- With NIGHT_FLASH_EN: night_mode=1 in MG -> FL. main_light toggles 010/000 per tick; after night_mode=0, the next tick enters AR2, then MG.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: main/side road intersection with pedestrian crossing.
// Phases advance on the 1 Hz tick enable. Requests are held in pending latches
// until served. All light outputs and the phase-change irq are registered.
// Optional macro NIGHT_FLASH_EN adds a night_mode input and the flashing
// phase FL (main yellow / side red blinking). Without it, FL is unreachable.
module traffic_phase_ctrl #(
    parameter int GREEN_TICKS  = 10,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 8,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       side_req,
`ifdef NIGHT_FLASH_EN
    input  logic       night_mode,
`endif
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] phase,
    output logic       irq
);

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5,
        WK  = 3'd6,
        FL  = 3'd7
    } state_t;

    // Last counter value of each phase; the phase exits on the tick seen here.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TICKS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ped_pend, side_pend;
    logic             flash, flash_nxt;
    logic [2:0]       main_nxt, side_nxt;
    logic             walk_nxt;
    logic             changing;

    assign changing = (state_nxt != state);
    assign phase    = state;

    // Next-phase selection; every transition is qualified by tick.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_nxt unassigned, which would otherwise infer a latch.
        state_nxt = state;
        if (tick) begin
            case (state)
                MG: begin
`ifdef NIGHT_FLASH_EN
                    if (night_mode)
                        state_nxt = FL;
                    else
`endif
                    if (cnt == GREEN_LAST && (ped_pend || side_pend))
                        state_nxt = MY;
                end
                MY:  if (cnt == YELLOW_LAST) state_nxt = AR1;
                AR1: if (cnt == ALLRED_LAST) state_nxt = ped_pend ? WK : SG;
                SG:  if (cnt == GREEN_LAST)  state_nxt = SY;
                SY:  if (cnt == YELLOW_LAST) state_nxt = AR2;
                AR2: if (cnt == ALLRED_LAST) state_nxt = MG;
                WK:  if (cnt == WALK_LAST)   state_nxt = AR2;
                FL: begin
`ifdef NIGHT_FLASH_EN
                    if (!night_mode) state_nxt = AR2;
`else
                    state_nxt = MG;
`endif
                end
            endcase
        end
    end

    // Phase counter and flash phase: clear on change, advance on tick.
    always_comb begin
        cnt_nxt   = cnt;
        flash_nxt = flash;
        if (changing)
            cnt_nxt = '0;
        else if (tick && state != FL && !(state == MG && cnt == GREEN_LAST))
            cnt_nxt = cnt + CNT_W'(1);
        if (changing && state_nxt == FL)
            flash_nxt = 1'b1;
        else if (state == FL && tick)
            flash_nxt = ~flash;
    end

    // Light decode of the upcoming phase so outputs land with the new phase.
    always_comb begin
        main_nxt = 3'b100;
        side_nxt = 3'b100;
        walk_nxt = 1'b0;
        case (state_nxt)
            MG: main_nxt = 3'b001;
            MY: main_nxt = 3'b010;
            SG: side_nxt = 3'b001;
            SY: side_nxt = 3'b010;
            WK: walk_nxt = 1'b1;
            FL: begin
                main_nxt = flash_nxt ? 3'b010 : 3'b000;
                side_nxt = flash_nxt ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in every clocked block so all
        // registers sample the pre-edge values regardless of block order.
        if (!rst_n) state <= MG;
        else        state <= state_nxt;
    end

    // Counter, flash bit and pending request latches (set wins over clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            flash     <= 1'b0;
            ped_pend  <= 1'b0;
            side_pend <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            flash     <= flash_nxt;
            ped_pend  <= ped_req  | (ped_pend  & ~(changing && state_nxt == WK));
            side_pend <= side_req | (side_pend & ~(changing && state_nxt == SG));
        end
    end

    // Registered lamp outputs and one-cycle phase-change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_light <= 3'b001;
            side_light <= 3'b100;
            walk       <= 1'b0;
            irq        <= 1'b0;
        end else begin
            main_light <= main_nxt;
            side_light <= side_nxt;
            walk       <= walk_nxt;
            irq        <= changing;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl. A behavioural model tracks the
// phase, elapsed ticks and pending requests and predicts every output.
module tb_traffic_phase_ctrl;

    localparam int G = 10;
    localparam int Y = 3;
    localparam int A = 2;
    localparam int W = 8;
    localparam logic [10:0] RESET_OBS = 11'b000_001_100_0_0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       side_req = 1'b0;
    logic       night_mode = 1'b0;
    logic [2:0] main_light, side_light, phase;
    logic       walk, irq;
    logic [10:0] obs;

    int checks = 0;
    int errors = 0;

    // Model state.
    int m_phase, m_el;
    bit m_ped, m_side, m_flash, m_irq;

    always #5 clk = ~clk;

    assign obs = {phase, main_light, side_light, walk, irq};

    traffic_phase_ctrl #(
        .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A), .WALK_TICKS(W), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .ped_req(ped_req),
        .side_req(side_req),
`ifdef NIGHT_FLASH_EN
        .night_mode(night_mode),
`endif
        .main_light(main_light),
        .side_light(side_light),
        .walk(walk),
        .phase(phase),
        .irq(irq)
    );

    function automatic int dur(input int p);
        case (p)
            1, 4:    return Y;
            2, 5:    return A;
            6:       return W;
            default: return G;
        endcase
    endfunction

    function automatic logic [10:0] model_obs();
        logic [2:0] ml, sl;
        logic       wk;
        ml = 3'b100; sl = 3'b100; wk = 1'b0;
        case (m_phase)
            0: ml = 3'b001;
            1: ml = 3'b010;
            3: sl = 3'b001;
            4: sl = 3'b010;
            6: wk = 1'b1;
            7: begin
                ml = m_flash ? 3'b010 : 3'b000;
                sl = m_flash ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
        return {3'(m_phase), ml, sl, wk, m_irq};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_el = 0; m_ped = 0; m_side = 0; m_flash = 0; m_irq = 0;
    endtask

    // Applies one cycle of inputs to the model using the phase rules.
    task automatic model_advance(input bit tk, input bit pr, input bit sr, input bit nm);
        int nxt;
        bit last, entered;
        nxt  = m_phase;
        last = (m_el + 1 >= dur(m_phase));
        if (tk) begin
            case (m_phase)
                0: if (nm) nxt = 7; else if (last && (m_ped || m_side)) nxt = 1;
                1: if (last) nxt = 2;
                2: if (last) nxt = m_ped ? 6 : 3;
                3: if (last) nxt = 4;
                4: if (last) nxt = 5;
                5: if (last) nxt = 0;
                6: if (last) nxt = 5;
                default: if (!nm) nxt = 5;
            endcase
        end
        entered = (nxt != m_phase);
        m_ped  = pr || (m_ped  && !(entered && nxt == 6));
        m_side = sr || (m_side && !(entered && nxt == 3));
        if (entered && nxt == 7) m_flash = 1;
        else if (m_phase == 7 && tk) m_flash = !m_flash;
        m_el    = entered ? 0 : (tk ? m_el + 1 : m_el);
        m_irq   = entered;
        m_phase = nxt;
    endtask

    // Drives one clock cycle of inputs; leaves time at posedge + 1.
    task automatic step(input bit tk, input bit pr, input bit sr);
        tick = tk; ped_req = pr; side_req = sr;
        model_advance(tk, pr, sr, night_mode);
        @(posedge clk);
        #1;
        tick = 1'b0; ped_req = 1'b0; side_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick = 1'b0; ped_req = 1'b0; side_req = 1'b0; night_mode = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (obs !== RESET_OBS) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs, RESET_OBS);
        end
    endtask

    task automatic test_idle();
        int irqs;
        irqs = 0;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            step(i % 2 == 0, 0, 0);
            irqs += int'(irq);
            checks++;
            if (obs !== RESET_OBS) begin
                errors++;
                $display("FAIL idle cyc %0d: got %b expected %b", i, obs, RESET_OBS);
            end
        end
        checks++;
        if (irqs != 0) begin
            errors++;
            $display("FAIL idle_irq: got %0d pulses expected 0", irqs);
        end
    endtask

    task automatic test_side_req();
        int t, first_exit, irqs;
        bit sent, done;
        t = 0; first_exit = -1; irqs = 0; sent = 0; done = 0;
        apply_reset();
        for (int c = 0; c < 200 && !done; c++) begin
            if (t == 2 && !sent) begin
                step(0, 0, 1);
                sent = 1;
            end else begin
                step(1, 0, 0);
                t++;
            end
            irqs += int'(irq);
            if (phase == 3'd1 && first_exit < 0) first_exit = t;
            if (phase == 3'd0 && first_exit >= 0) done = 1;
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL side_seq cyc %0d: got %b expected %b", c, obs, model_obs());
            end
        end
        checks++;
        if (!done || first_exit != 10 || irqs != 6) begin
            errors++;
            $display("FAIL side_summary: done %0d exit_tick %0d irqs %0d expected 1 10 6",
                     done, first_exit, irqs);
        end
        // side_pend was cleared on SG entry: MG must now hold.
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0);
            checks++;
            if (obs !== RESET_OBS) begin
                errors++;
                $display("FAIL side_cleared tick %0d: got %b expected %b", i, obs, RESET_OBS);
            end
        end
    endtask

    task automatic test_ped_and_side();
        int exp_seq[8] = '{1, 2, 6, 5, 0, 1, 2, 3};
        int seq[$];
        int walks;
        walks = 0;
        apply_reset();
        step(0, 1, 1);
        for (int c = 0; c < 200 && seq.size() < 8; c++) begin
            step(1, 0, 0);
            if (irq) seq.push_back(int'(phase));
            walks += int'(walk);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL ped_side cyc %0d: got %b expected %b", c, obs, model_obs());
            end
        end
        checks++;
        if (seq.size() != 8) begin
            errors++;
            $display("FAIL ped_side_timeout: got %0d phase changes expected 8", seq.size());
        end
        for (int i = 0; i < seq.size() && i < 8; i++) begin
            checks++;
            if (seq[i] != exp_seq[i]) begin
                errors++;
                $display("FAIL ped_side_order %0d: got %0d expected %0d", i, seq[i], exp_seq[i]);
            end
        end
        checks++;
        if (walks != W) begin
            errors++;
            $display("FAIL walk_len: got %0d expected %0d", walks, W);
        end
    endtask

    task automatic test_req_on_sg_entry();
        int exp_seq[6] = '{4, 5, 0, 1, 2, 3};
        int seq[$];
        apply_reset();
        step(0, 0, 1);
        for (int c = 0; c < 100 && !(m_phase == 2 && m_el == A - 1); c++) step(1, 0, 0);
        step(1, 0, 1);
        checks++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL sg_entry: got phase %0d expected 3", phase);
        end
        for (int c = 0; c < 100 && seq.size() < 6; c++) begin
            step(1, 0, 0);
            if (irq) seq.push_back(int'(phase));
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL sg_resend cyc %0d: got %b expected %b", c, obs, model_obs());
            end
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= seq.size() || seq[i] != exp_seq[i]) begin
                errors++;
                $display("FAIL sg_resend_order %0d: got %0d expected %0d",
                         i, (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_sg();
        apply_reset();
        step(0, 0, 1);
        for (int c = 0; c < 100 && !(m_phase == 3 && m_el == 5); c++) step(1, 0, 0);
        checks++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL mid_sg_reach: got phase %0d expected 3", phase);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (obs !== RESET_OBS) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", obs, RESET_OBS);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 1);
        for (int i = 1; i <= G; i++) begin
            step(1, 0, 0);
            checks++;
            if (obs !== model_obs() || phase !== ((i < G) ? 3'd0 : 3'd1)) begin
                errors++;
                $display("FAIL post_reset tick %0d: got %b expected %b", i, obs, model_obs());
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            step(1, $urandom_range(15) == 0, $urandom_range(15) == 0);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL b2b cyc %0d: got %b expected %b", c, obs, model_obs());
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(3) == 0, $urandom_range(39) == 0, $urandom_range(39) == 0);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b expected %b", c, obs, model_obs());
            end
        end
    endtask

`ifdef NIGHT_FLASH_EN
    task automatic test_night();
        int irqs;
        irqs = 0;
        apply_reset();
        night_mode = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(1, c == 3, 0);
            irqs += int'(irq);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL night cyc %0d: got %b expected %b", c, obs, model_obs());
            end
        end
        checks++;
        if (irqs != 1) begin
            errors++;
            $display("FAIL night_irq: got %0d expected 1", irqs);
        end
        night_mode = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step(1, 0, 0);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL night_exit cyc %0d: got %b expected %b", c, obs, model_obs());
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_side_req();
        test_ped_and_side();
        test_req_on_sg_entry();
        test_reset_mid_sg();
        test_back_to_back();
        test_random();
`ifdef NIGHT_FLASH_EN
        test_night();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
